// File: rtl/mac_pkg.sv
// Shared types and saturating-add helper for the MAC dot-product engine.
package mac_pkg;

    typedef enum logic [1:0] {IDLE, MUL, ACC} mac_state_t;

    // Widest accumulator the helper supports; callers zero-extend into it.
    localparam int MAX_ACC = 128;

    typedef struct packed {
        logic               ovf;
        logic [MAX_ACC-1:0] val;
    } sat_res_t;

    // sum holds an (aw+1)-bit extended sum; returns the aw-bit result.
    function automatic sat_res_t sat_add(
        input logic [MAX_ACC:0] sum,
        input logic [7:0]       aw,
        input logic             mode,
        input logic             sat_en
    );
        sat_res_t           r;
        logic [MAX_ACC-1:0] mask;
        logic [MAX_ACC-1:0] smax;
        logic               top_b;
        logic               msb_b;
        mask  = (MAX_ACC'(1) << aw) - MAX_ACC'(1);
        smax  = mask >> 1;
        top_b = sum[aw];
        msb_b = sum[aw - 8'd1];
        r.ovf = mode ? (top_b ^ msb_b) : top_b;
        if (r.ovf && sat_en) begin
            r.val = mode ? (top_b ? (mask & ~smax) : smax) : mask;
        end else begin
            r.val = sum[MAX_ACC-1:0] & mask;
        end
        return r;
    endfunction

endpackage

// File: rtl/mac_dot_engine_mult.sv
// Iterative shift-add multiplier: one partial product per cycle,
// magnitudes in signed mode with a final sign fix-up.
module mac_seq_mult #(
    parameter int DATA_WIDTH = 16
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    i_start,
    input  logic                    i_abort,
    input  logic                    i_signed,
    input  logic [DATA_WIDTH-1:0]   i_a,
    input  logic [DATA_WIDTH-1:0]   i_b,
    output logic                    o_done,
    output logic [2*DATA_WIDTH-1:0] o_prod
);
    localparam int PW = 2 * DATA_WIDTH;
    localparam int CW = $clog2(DATA_WIDTH);

    logic [PW-1:0]         r_mcand;
    logic [PW-1:0]         r_acc;
    logic [DATA_WIDTH-1:0] r_mplier;
    logic [CW-1:0]         r_cnt;
    logic                  r_run;
    logic                  r_neg;
    logic                  w_neg_a;
    logic                  w_neg_b;
    logic [DATA_WIDTH-1:0] w_mag_a;
    logic [DATA_WIDTH-1:0] w_mag_b;

    // -2^(W-1) negates to itself, which is its correct unsigned magnitude.
    assign w_neg_a = i_signed & i_a[DATA_WIDTH-1];
    assign w_neg_b = i_signed & i_b[DATA_WIDTH-1];
    assign w_mag_a = w_neg_a ? -i_a : i_a;
    assign w_mag_b = w_neg_b ? -i_b : i_b;
    assign o_done  = r_run && (r_cnt == CW'(DATA_WIDTH - 1));
    assign o_prod  = r_neg ? -r_acc : r_acc;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_mcand  <= '0;
            r_acc    <= '0;
            r_mplier <= '0;
            r_cnt    <= '0;
            r_run    <= 1'b0;
            r_neg    <= 1'b0;
        end else if (i_abort) begin
            r_run <= 1'b0;
        end else if (i_start) begin
            r_mcand  <= {{DATA_WIDTH{1'b0}}, w_mag_a};
            r_mplier <= w_mag_b;
            r_acc    <= '0;
            r_cnt    <= '0;
            r_run    <= 1'b1;
            r_neg    <= w_neg_a ^ w_neg_b;
        end else if (r_run) begin
            if (r_mplier[0]) begin
                r_acc <= r_acc + r_mcand;
            end
            r_mcand  <= r_mcand << 1;
            r_mplier <= r_mplier >> 1;
            r_cnt    <= r_cnt + 1'b1;
            if (o_done) begin
                r_run <= 1'b0;
            end
        end
    end

endmodule

// File: rtl/mac_dot_engine.sv
// Sequential multiply-accumulate dot-product engine with valid/ready
// input, signed/unsigned accumulation and optional saturation.
module mac_dot_engine
    import mac_pkg::*;
#(
    parameter int DATA_WIDTH = 16,
    parameter int ACC_WIDTH  = 40
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic [DATA_WIDTH-1:0] a_in,
    input  logic [DATA_WIDTH-1:0] b_in,
    input  logic                  last_in,
    input  logic                  signed_mode,
    input  logic                  sat_en,
    input  logic                  clr_acc,
    output logic [ACC_WIDTH-1:0]  acc_out,
    output logic [ACC_WIDTH-1:0]  result_out,
    output logic                  result_valid,
    output logic                  overflow,
    output logic                  busy
);
    localparam int PW = 2 * DATA_WIDTH;

    mac_state_t             r_state;
    mac_state_t             w_next;
    logic                   w_accept;
    logic                   w_done;
    logic                   r_last;
    logic                   r_signed;
    logic                   r_sat;
    logic [ACC_WIDTH-1:0]   r_acc;
    logic [ACC_WIDTH-1:0]   r_result;
    logic                   r_rv;
    logic                   r_ovf;
    logic [PW-1:0]          w_prod;
    logic [ACC_WIDTH:0]     w_acc_ext;
    logic [ACC_WIDTH:0]     w_prod_ext;
    logic [ACC_WIDTH:0]     w_sum;
    sat_res_t               w_sat;

    assign w_accept = in_valid && in_ready;

    mac_seq_mult #(.DATA_WIDTH(DATA_WIDTH)) u_mult (
        .clk      (clk),
        .rst_n    (rst_n),
        .i_start  (w_accept),
        .i_abort  (clr_acc),
        .i_signed (signed_mode),
        .i_a      (a_in),
        .i_b      (b_in),
        .o_done   (w_done),
        .o_prod   (w_prod)
    );

    // One extra bit exposes signed overflow or unsigned carry.
    assign w_prod_ext = r_signed
        ? {{(ACC_WIDTH + 1 - PW){w_prod[PW-1]}}, w_prod}
        : {{(ACC_WIDTH + 1 - PW){1'b0}}, w_prod};
    assign w_acc_ext  = {r_signed & r_acc[ACC_WIDTH-1], r_acc};
    assign w_sum      = w_acc_ext + w_prod_ext;
    assign w_sat      = sat_add({{(MAX_ACC - ACC_WIDTH){1'b0}}, w_sum},
                                8'(ACC_WIDTH), r_signed, r_sat);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    always_comb begin
        w_next = r_state;
        if (clr_acc) begin
            w_next = IDLE;
        end else begin
            unique case (r_state)
                IDLE:    if (w_accept) w_next = MUL;
                MUL:     if (w_done) w_next = ACC;
                ACC:     w_next = IDLE;
                default: w_next = IDLE;
            endcase
        end
    end

    always_comb begin
        in_ready = (r_state == IDLE) && !clr_acc;
        busy     = (r_state != IDLE);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_last   <= 1'b0;
            r_signed <= 1'b0;
            r_sat    <= 1'b0;
            r_acc    <= '0;
            r_result <= '0;
            r_rv     <= 1'b0;
            r_ovf    <= 1'b0;
        end else begin
            r_rv <= 1'b0;
            if (clr_acc) begin
                r_acc <= '0;
                r_ovf <= 1'b0;
            end else begin
                if (w_accept) begin
                    r_last   <= last_in;
                    r_signed <= signed_mode;
                    r_sat    <= sat_en;
                end
                if (r_state == ACC) begin
                    r_ovf <= r_ovf | w_sat.ovf;
                    if (r_last) begin
                        r_result <= w_sat.val[ACC_WIDTH-1:0];
                        r_rv     <= 1'b1;
                        r_acc    <= '0;
                    end else begin
                        r_acc <= w_sat.val[ACC_WIDTH-1:0];
                    end
                end
            end
        end
    end

    assign acc_out      = r_acc;
    assign result_out   = r_result;
    assign result_valid = r_rv;
    assign overflow     = r_ovf;

endmodule

// File: tb/tb_mac_dot_engine.sv
// Randomised and directed bench for mac_dot_engine at two accumulator
// widths, checked each cycle against a transaction-level model.
module tb_mac_dot_engine;
    localparam int W  = 16;
    localparam int A0 = 40;
    localparam int A1 = 32;

    logic          clk = 0;
    logic          rst_n = 0;
    logic          in_valid = 0;
    logic          last_in = 0;
    logic          signed_mode = 0;
    logic          sat_en = 0;
    logic          clr_acc = 0;
    logic [W-1:0]  a_in = '0;
    logic [W-1:0]  b_in = '0;
    logic [A0-1:0] acc0, res0;
    logic [A1-1:0] acc1, res1;
    logic          rdy0, rdy1, rv0, rv1, ov0, ov1, bz0, bz1;

    always #5 clk = ~clk;

    mac_dot_engine #(.DATA_WIDTH(W), .ACC_WIDTH(A0)) u_dut0 (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(rdy0),
        .a_in(a_in), .b_in(b_in), .last_in(last_in),
        .signed_mode(signed_mode), .sat_en(sat_en), .clr_acc(clr_acc),
        .acc_out(acc0), .result_out(res0), .result_valid(rv0),
        .overflow(ov0), .busy(bz0)
    );

    mac_dot_engine #(.DATA_WIDTH(W), .ACC_WIDTH(A1)) u_dut1 (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(rdy1),
        .a_in(a_in), .b_in(b_in), .last_in(last_in),
        .signed_mode(signed_mode), .sat_en(sat_en), .clr_acc(clr_acc),
        .acc_out(acc1), .result_out(res1), .result_valid(rv1),
        .overflow(ov1), .busy(bz1)
    );

    int     n_cmp = 0;
    int     n_bad = 0;
    longint cyc = 0;

    task automatic chk(input string nm, input logic [63:0] act,
                       input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)",
                     nm, act, exp, cyc);
        end
    endtask

    // Transaction-level model: one pending beat resolves W+1 edges after accept.
    longint       m_acc[2];
    longint       m_res[2];
    bit           m_rv[2];
    bit           m_ovf[2];
    bit           m_pend = 0;
    int           m_k = 0;
    logic [W-1:0] m_a, m_b;
    bit           m_last, m_sm, m_sat;
    longint       acc_q[$];

    initial begin
        m_acc = '{0, 0};
        m_res = '{0, 0};
        m_rv  = '{0, 0};
        m_ovf = '{0, 0};
    end

    function automatic int aw(input int i);
        return (i == 0) ? A0 : A1;
    endfunction

    function automatic void beat(input int i);
        longint two, pa, pb, av, sum, hi, lo, clamp, nv;
        bit     ovf;
        two = longint'(1) << aw(i);
        pa  = m_sm ? longint'($signed(m_a)) : longint'(m_a);
        pb  = m_sm ? longint'($signed(m_b)) : longint'(m_b);
        av  = m_acc[i];
        if (m_sm && av >= two / 2) av = av - two;
        sum = av + pa * pb;
        if (m_sm) begin
            hi    = two / 2 - 1;
            lo    = -(two / 2);
            ovf   = (sum > hi) || (sum < lo);
            clamp = (sum > hi) ? hi : lo;
        end else begin
            ovf   = (sum >= two);
            clamp = two - 1;
        end
        if (ovf) m_ovf[i] = 1;
        nv = (ovf && m_sat) ? clamp : sum;
        nv = nv & (two - 1);
        if (m_last) begin
            m_res[i] = nv;
            m_rv[i]  = 1;
            m_acc[i] = 0;
        end else begin
            m_acc[i] = nv;
        end
    endfunction

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_acc  = '{0, 0};
            m_res  = '{0, 0};
            m_rv   = '{0, 0};
            m_ovf  = '{0, 0};
            m_pend = 0;
            m_k    = 0;
        end else begin
            cyc++;
            m_rv = '{0, 0};
            if (clr_acc) begin
                m_acc  = '{0, 0};
                m_ovf  = '{0, 0};
                m_pend = 0;
            end else if (m_pend) begin
                m_k++;
                if (m_k == W + 1) begin
                    beat(0);
                    beat(1);
                    m_pend = 0;
                end
            end else if (in_valid) begin
                m_pend = 1;
                m_k    = 0;
                m_a    = a_in;
                m_b    = b_in;
                m_last = last_in;
                m_sm   = signed_mode;
                m_sat  = sat_en;
                acc_q.push_back(cyc);
            end
        end
    end

    always @(negedge clk) begin
        chk("acc40",   64'(acc0), 64'(m_acc[0]));
        chk("res40",   64'(res0), 64'(m_res[0]));
        chk("rv40",    64'(rv0),  64'(m_rv[0]));
        chk("ovf40",   64'(ov0),  64'(m_ovf[0]));
        chk("acc32",   64'(acc1), 64'(m_acc[1]));
        chk("res32",   64'(res1), 64'(m_res[1]));
        chk("rv32",    64'(rv1),  64'(m_rv[1]));
        chk("ovf32",   64'(ov1),  64'(m_ovf[1]));
        chk("ready40", 64'(rdy0), 64'(!m_pend && !clr_acc));
        chk("ready32", 64'(rdy1), 64'(!m_pend && !clr_acc));
        chk("busy40",  64'(bz0),  64'(m_pend));
        chk("busy32",  64'(bz1),  64'(m_pend));
    end

    task automatic wait_idle();
        int n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!rdy0 && n < 100);
        if (!rdy0) chk("idle_timeout", 64'(rdy0), 64'd1);
    endtask

    task automatic send(input logic [W-1:0] a, input logic [W-1:0] b,
                        input bit last, input bit sm, input bit sat);
        int n = 0;
        @(posedge clk);
        #1;
        in_valid    = 1;
        a_in        = a;
        b_in        = b;
        last_in     = last;
        signed_mode = sm;
        sat_en      = sat;
        do begin
            @(negedge clk);
            n++;
        end while (!rdy0 && n < 100);
        if (!rdy0) begin
            chk("accept_timeout", 64'(rdy0), 64'd1);
            in_valid = 0;
            return;
        end
        @(posedge clk);
        #1;
        in_valid    = 0;
        a_in        = W'($urandom);
        b_in        = W'($urandom);
        last_in     = 1'($urandom);
        signed_mode = 1'($urandom);
        sat_en      = 1'($urandom);
        wait_idle();
    endtask

    task automatic clear();
        @(posedge clk);
        #1;
        clr_acc = 1;
        @(posedge clk);
        #1;
        clr_acc = 0;
    endtask

    function automatic logic [W-1:0] pick();
        case ($urandom_range(0, 5))
            0: return '0;
            1: return 16'h8000;
            2: return 16'h7FFF;
            3: return 16'hFFFF;
            default: return W'($urandom);
        endcase
    endfunction

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        bit sm, st, lst;
        repeat (3) @(negedge clk);
        chk("rst_acc",   64'(acc0), 64'd0);
        chk("rst_res",   64'(res0), 64'd0);
        chk("rst_ready", 64'(rdy0), 64'd1);
        chk("rst_busy",  64'(bz0),  64'd0);
        rst_n = 1;

        // Signed dot product 10*5 + 2*-3 + 100*10
        clear();
        send(16'd10, 16'd5, 0, 1, 0);
        chk("t1_acc50", 64'(acc0), 64'd50);
        send(16'd2, 16'hFFFD, 0, 1, 0);
        chk("t1_acc44", 64'(acc0), 64'd44);
        send(16'd100, 16'd10, 1, 1, 0);
        chk("t1_res", 64'(res0), 64'd1044);
        chk("t1_rv",  64'(rv0),  64'd1);
        chk("t1_clr", 64'(acc0), 64'd0);
        @(negedge clk);
        chk("t1_pulse", 64'(rv0), 64'd0);

        // Back-to-back accepts with in_valid held and operands churning
        clear();
        @(posedge clk);
        #1;
        acc_q.delete();
        in_valid    = 1;
        last_in     = 0;
        signed_mode = 0;
        sat_en      = 0;
        repeat (3 * (W + 2) + 1) begin
            a_in = W'($urandom);
            b_in = W'($urandom);
            @(posedge clk);
            #1;
        end
        in_valid = 0;
        wait_idle();
        chk("t2_count", 64'(acc_q.size() >= 3), 64'd1);
        for (int i = 1; i < acc_q.size(); i++)
            chk("t2_spacing", 64'(acc_q[i] - acc_q[i-1]), 64'(W + 2));

        // Product extremes
        clear();
        send(16'hFFFF, 16'hFFFF, 0, 0, 0);
        chk("t3_uu40", 64'(acc0), 64'hFFFE0001);
        chk("t3_uu32", 64'(acc1), 64'hFFFE0001);
        clear();
        send(16'h8000, 16'h8000, 0, 1, 0);
        chk("t3_nn", 64'(acc0), 64'h40000000);
        clear();
        send(16'h8000, 16'h7FFF, 0, 1, 0);
        chk("t3_np40", 64'(acc0), 64'hFF_C000_8000);
        chk("t3_np32", 64'(acc1), 64'hC000_8000);

        // Signed saturation vs wrap on the 32-bit instance
        clear();
        repeat (3) send(16'h7FFF, 16'h7FFF, 0, 1, 1);
        chk("t4_sat",   64'(acc1), 64'h7FFF_FFFF);
        chk("t4_ovf",   64'(ov1),  64'd1);
        chk("t4_wide",  64'(acc0), 64'hBFFD_0003);
        chk("t4_wovf",  64'(ov0),  64'd0);
        clear();
        repeat (3) send(16'h7FFF, 16'h7FFF, 0, 1, 0);
        chk("t4_wrap",  64'(acc1), 64'hBFFD_0003);
        chk("t4_wrovf", 64'(ov1),  64'd1);

        // Clear during MUL aborts the beat
        @(posedge clk);
        #1;
        in_valid    = 1;
        a_in        = 16'd3;
        b_in        = 16'd4;
        last_in     = 1;
        signed_mode = 1;
        sat_en      = 0;
        @(posedge clk);
        #1;
        in_valid = 0;
        repeat (5) @(posedge clk);
        #1;
        clr_acc = 1;
        @(posedge clk);
        #1;
        clr_acc = 0;
        @(negedge clk);
        chk("t5_acc",   64'(acc1), 64'd0);
        chk("t5_ovf",   64'(ov1),  64'd0);
        chk("t5_ready", 64'(rdy0), 64'd1);
        repeat (20) @(negedge clk);
        chk("t5_noacc", 64'(acc0), 64'd0);
        chk("t5_res",   64'(res0), 64'd1044);
        @(posedge clk);
        #1;
        clr_acc  = 1;
        in_valid = 1;
        a_in     = 16'd7;
        b_in     = 16'd7;
        @(posedge clk);
        #1;
        clr_acc  = 0;
        in_valid = 0;
        @(negedge clk);
        chk("t5_noaccept", 64'(bz0), 64'd0);

        // Asynchronous reset during MUL
        @(posedge clk);
        #1;
        in_valid    = 1;
        a_in        = 16'd9;
        b_in        = 16'd9;
        last_in     = 0;
        signed_mode = 1;
        @(posedge clk);
        #1;
        in_valid = 0;
        repeat (4) @(posedge clk);
        #2;
        rst_n = 0;
        #1;
        chk("t6_ready", 64'(rdy0), 64'd1);
        chk("t6_busy",  64'(bz0),  64'd0);
        chk("t6_res",   64'(res0), 64'd0);
        chk("t6_acc",   64'(acc0), 64'd0);
        @(negedge clk);
        rst_n = 1;
        send(16'd6, 16'd7, 1, 1, 0);
        chk("t6_next", 64'(res0), 64'd42);

        // Randomised dot products with occasional clears
        clear();
        sm = 1'($urandom);
        st = 1'($urandom);
        for (int i = 0; i < 80; i++) begin
            if ($urandom_range(0, 9) == 0) begin
                clear();
                sm = 1'($urandom);
                st = 1'($urandom);
            end
            repeat ($urandom_range(0, 3)) @(posedge clk);
            lst = ($urandom_range(0, 3) == 0);
            send(pick(), pick(), lst, sm, st);
            if (lst) begin
                sm = 1'($urandom);
                st = 1'($urandom);
            end
        end
        repeat (3) @(negedge clk);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
